// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: packet-granular arbiter driving the single ULPI TX AXI-Stream
// from three sources (S0 handshake responder, S1 control EP, S2 bulk EP).
// The grant is made in IDLE and held for the whole packet. Data passes through
// combinationally while transferring. A fixed inter-packet gap follows each packet,
// and a bus reset mid-packet drains the rest of the granted packet.
module usb_tx_arbiter #(
  parameter int unsigned IPG_CYCLES = 8,
  parameter bit          RR_ENABLE  = 1'b1
) (
  input  logic       ulpi_clk,
  input  logic       rst,
  input  logic       usb_idle_i,
  input  logic       usb_reset_i,
  input  logic       s0_tvalid_i,
  output logic       s0_tready_o,
  input  logic       s0_tlast_i,
  input  logic [7:0] s0_tdata_i,
  input  logic       s1_tvalid_i,
  output logic       s1_tready_o,
  input  logic       s1_tlast_i,
  input  logic [7:0] s1_tdata_i,
  input  logic       s2_tvalid_i,
  output logic       s2_tready_o,
  input  logic       s2_tlast_i,
  input  logic [7:0] s2_tdata_i,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic [7:0] m_tdata_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       flush_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // The gap counter is loaded with IPG-1 so that the gap lasts exactly IPG cycles.
  localparam bit         NO_GAP   = (IPG_CYCLES == 32'd0);
  localparam logic [7:0] IPG_LOAD = 8'((IPG_CYCLES == 32'd0) ? 32'd0 : IPG_CYCLES - 32'd1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;        // 0: S1 is next in the round-robin, 1: S2 is next
  logic [7:0] cnt_q, cnt_d;
  logic       flush_q;

  logic       g_tvalid;
  logic       g_tlast;
  logic [7:0] g_tdata;
  logic       g_tready;
  logic       pkt_end;

  // Select the stream of the current owner.
  always_comb begin
    g_tvalid = s0_tvalid_i;
    g_tlast  = s0_tlast_i;
    g_tdata  = s0_tdata_i;
    case (grant_q)
      2'd1: begin
        g_tvalid = s1_tvalid_i;
        g_tlast  = s1_tlast_i;
        g_tdata  = s1_tdata_i;
      end
      2'd2: begin
        g_tvalid = s2_tvalid_i;
        g_tlast  = s2_tlast_i;
        g_tdata  = s2_tdata_i;
      end
      default: begin
        g_tvalid = s0_tvalid_i;
        g_tlast  = s0_tlast_i;
        g_tdata  = s0_tdata_i;
      end
    endcase
  end

  // Next state, grant selection, round-robin pointer and gap counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    pkt_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (usb_idle_i && !usb_reset_i && (s0_tvalid_i || s1_tvalid_i || s2_tvalid_i)) begin
          state_d = ST_XFER;
          if (s0_tvalid_i) begin
            grant_d = 2'd0;  // S0 wins and does not disturb the S1/S2 rotation
          end else if (s1_tvalid_i && (!s2_tvalid_i || !RR_ENABLE || !rr_q)) begin
            grant_d = 2'd1;
            rr_d    = 1'b1;
          end else begin
            grant_d = 2'd2;
            rr_d    = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // A completing last beat beats a coincident bus reset.
        if (g_tvalid && m_tready_i && g_tlast) begin
          pkt_end = 1'b1;
        end else if (usb_reset_i) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_FLUSH: begin
        pkt_end = g_tvalid && g_tlast;
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (pkt_end) begin
      if (NO_GAP) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_GAP;
        cnt_d   = IPG_LOAD;
      end
    end
  end

  // Stream outputs and per-source readies; only the owner ever sees ready.
  always_comb begin
    m_tvalid_o  = 1'b0;
    m_tlast_o   = 1'b0;
    m_tdata_o   = 8'h00;
    g_tready    = 1'b0;
    s0_tready_o = 1'b0;
    s1_tready_o = 1'b0;
    s2_tready_o = 1'b0;
    case (state_q)
      ST_XFER: begin
        m_tvalid_o = g_tvalid;
        m_tlast_o  = g_tlast;
        m_tdata_o  = g_tdata;
        g_tready   = m_tready_i;
      end
      ST_FLUSH: g_tready = 1'b1;
      default:  g_tready = 1'b0;
    endcase
    case (grant_q)
      2'd1:    s1_tready_o = g_tready;
      2'd2:    s2_tready_o = g_tready;
      default: s0_tready_o = g_tready;
    endcase
  end

  // State, grant, pointer, counter and flush-pulse registers.
  always_ff @(posedge ulpi_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      flush_q <= (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign flush_o = flush_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: drives queued packets from three AXI-Stream sources and
// compares the delivered stream against a packet-level arbitration model.
module tb_usb_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       usb_idle, usb_reset, m_tready;
  logic       sv [3];
  logic       sl [3];
  logic [7:0] sd [3];
  bit         sel_alt;

  logic       p_st0, p_st1, p_st2, p_mv, p_ml, p_busy, p_mf;
  logic [7:0] p_md;
  logic [1:0] p_mg;
  logic       a_st0, a_st1, a_st2, a_mv, a_ml, a_busy, a_mf;
  logic [7:0] a_md;
  logic [1:0] a_mg;

  logic       st [3];
  logic       mv, ml, busy, mf;
  logic [7:0] md;
  logic [1:0] mg;

  // Source queues (driven stimulus) and model copies
  logic [7:0] q_data [3][$];
  logic       q_last [3][$];
  logic [7:0] m_bytes [3][$];
  int         m_len [3][$];
  // Expected and observed beats
  logic [1:0] e_g[$];
  logic [7:0] e_d[$];
  logic       e_l[$];
  logic [1:0] o_g[$];
  logic [7:0] o_d[$];
  logic       o_l[$];
  int         o_start[$];
  int         o_lastcyc[$];

  int n_pass = 0, n_total = 0;
  int cyc, rdy_mode, tready_err, flush_cnt, flush_mv_err;
  int popped [3];
  bit prev_mv;

  always #5 clk = ~clk;

  usb_tx_arbiter u_dut (
    .ulpi_clk(clk), .rst(rst), .usb_idle_i(usb_idle), .usb_reset_i(usb_reset),
    .s0_tvalid_i(sv[0]), .s0_tready_o(p_st0), .s0_tlast_i(sl[0]), .s0_tdata_i(sd[0]),
    .s1_tvalid_i(sv[1]), .s1_tready_o(p_st1), .s1_tlast_i(sl[1]), .s1_tdata_i(sd[1]),
    .s2_tvalid_i(sv[2]), .s2_tready_o(p_st2), .s2_tlast_i(sl[2]), .s2_tdata_i(sd[2]),
    .m_tvalid_o(p_mv), .m_tready_i(m_tready), .m_tlast_o(p_ml), .m_tdata_o(p_md),
    .grant_o(p_mg), .busy_o(p_busy), .flush_o(p_mf)
  );

  usb_tx_arbiter #(.IPG_CYCLES(0), .RR_ENABLE(1'b0)) u_alt (
    .ulpi_clk(clk), .rst(rst), .usb_idle_i(usb_idle), .usb_reset_i(usb_reset),
    .s0_tvalid_i(sv[0]), .s0_tready_o(a_st0), .s0_tlast_i(sl[0]), .s0_tdata_i(sd[0]),
    .s1_tvalid_i(sv[1]), .s1_tready_o(a_st1), .s1_tlast_i(sl[1]), .s1_tdata_i(sd[1]),
    .s2_tvalid_i(sv[2]), .s2_tready_o(a_st2), .s2_tlast_i(sl[2]), .s2_tdata_i(sd[2]),
    .m_tvalid_o(a_mv), .m_tready_i(m_tready), .m_tlast_o(a_ml), .m_tdata_o(a_md),
    .grant_o(a_mg), .busy_o(a_busy), .flush_o(a_mf)
  );

  // View of whichever instance the current test observes.
  always_comb begin
    if (sel_alt) begin
      st[0] = a_st0; st[1] = a_st1; st[2] = a_st2;
      mv = a_mv; ml = a_ml; md = a_md; mg = a_mg; busy = a_busy; mf = a_mf;
    end else begin
      st[0] = p_st0; st[1] = p_st1; st[2] = p_st2;
      mv = p_mv; ml = p_ml; md = p_md; mg = p_mg; busy = p_busy; mf = p_mf;
    end
  end

  task automatic add_pkt(input int s, input int len, input logic [39:0] bytes);
    for (int j = 0; j < len; j++) begin
      q_data[s].push_back(bytes[8*j +: 8]);
      q_last[s].push_back(j == len - 1);
      m_bytes[s].push_back(bytes[8*j +: 8]);
    end
    m_len[s].push_back(len);
  endtask

  // Packet-level model: S0 first, then S1/S2 by rotation (or S1 priority).
  task automatic build_expected(input bit rr_en);
    int ptr = 1;
    int s, len;
    e_g.delete(); e_d.delete(); e_l.delete();
    forever begin
      if (m_len[0].size() > 0) s = 0;
      else if (m_len[1].size() > 0 && m_len[2].size() > 0) s = rr_en ? ptr : 1;
      else if (m_len[1].size() > 0) s = 1;
      else if (m_len[2].size() > 0) s = 2;
      else break;
      if (s == 1) ptr = 2;
      else if (s == 2) ptr = 1;
      len = m_len[s].pop_front();
      for (int j = 0; j < len; j++) begin
        e_g.push_back(2'(s));
        e_d.push_back(m_bytes[s].pop_front());
        e_l.push_back(j == len - 1);
      end
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      q_data[s].delete(); q_last[s].delete(); m_bytes[s].delete(); m_len[s].delete();
      sv[s] = 1'b0; sl[s] = 1'b0; sd[s] = 8'h00; popped[s] = 0;
    end
    o_g.delete(); o_d.delete(); o_l.delete(); o_start.delete(); o_lastcyc.delete();
    usb_idle = 1'b1; usb_reset = 1'b0; m_tready = 1'b1; rdy_mode = 0;
    cyc = 0; prev_mv = 1'b0; tready_err = 0; flush_cnt = 0; flush_mv_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: present source heads at negedge, sample settled outputs, record.
  task automatic step();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sv[s] = (q_data[s].size() != 0);
      sd[s] = sv[s] ? q_data[s][0] : 8'h00;
      sl[s] = sv[s] ? q_last[s][0] : 1'b0;
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = cyc[0];
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    for (int s = 0; s < 3; s++) begin
      if (s != int'(mg) && st[s]) tready_err++;
      else if (s == int'(mg) && mv && st[s] !== m_tready) tready_err++;
    end
    if (mv && !prev_mv) o_start.push_back(cyc);
    prev_mv = mv;
    if (mv && m_tready) begin
      o_g.push_back(mg); o_d.push_back(md); o_l.push_back(ml);
      if (ml) o_lastcyc.push_back(cyc);
    end
    if (mf) flush_cnt++;
    if (flush_cnt > 0 && mv) flush_mv_err++;
    for (int s = 0; s < 3; s++) begin
      if (sv[s] && st[s]) begin
        void'(q_data[s].pop_front());
        void'(q_last[s].pop_front());
        popped[s]++;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    sel_alt = 1'b0;
    rst = 1'b1;
    usb_idle = 1'b1; usb_reset = 1'b0; m_tready = 1'b1;
    for (int s = 0; s < 3; s++) begin sv[s] = 1'b1; sl[s] = 1'b1; sd[s] = 8'hAA; end
    @(negedge clk); #1;
    n_total++;
    if ({mv, ml, md, mg, busy, mf, st[0], st[1], st[2]} !== 17'd0)
      $display("FAIL reset_outputs act=%h exp=0", {mv, ml, md, mg, busy, mf, st[0], st[1], st[2]});
    else n_pass++;
    reset_all();
    add_pkt(1, 5, 40'h5544332211);
    step(); step();
    n_total++;
    if (mv !== 1'b1) $display("FAIL async_pre_mv act=%b exp=1", mv); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({mv, busy, st[1]} !== 3'b000) $display("FAIL async_drop act=%b exp=000", {mv, busy, st[1]});
    else n_pass++;
  endtask

  task automatic test_s1_packet();
    reset_all(); sel_alt = 1'b0;
    add_pkt(1, 3, 40'h00002211C3);
    build_expected(1'b1);
    repeat (16) step();
    n_total++;
    if (o_d.size() !== e_d.size()) $display("FAIL s1_beats act=%0d exp=%0d", o_d.size(), e_d.size());
    else n_pass++;
    for (int i = 0; i < o_d.size() && i < e_d.size(); i++) begin
      n_total++;
      if ({o_g[i], o_d[i], o_l[i]} !== {e_g[i], e_d[i], e_l[i]})
        $display("FAIL s1_beat%0d act=%h exp=%h", i, {o_g[i], o_d[i], o_l[i]}, {e_g[i], e_d[i], e_l[i]});
      else n_pass++;
    end
    n_total++;
    if ({busy, mg} !== 3'b001) $display("FAIL s1_idle_grant act=%b exp=001", {busy, mg}); else n_pass++;
  endtask

  task automatic test_s0_priority_gap();
    reset_all(); sel_alt = 1'b0;
    add_pkt(0, 1, 40'h00000000D2);
    add_pkt(2, 2, 40'h0000005A69);
    build_expected(1'b1);
    repeat (24) step();
    for (int i = 0; i < o_d.size() && i < e_d.size(); i++) begin
      n_total++;
      if ({o_g[i], o_d[i], o_l[i]} !== {e_g[i], e_d[i], e_l[i]})
        $display("FAIL prio_beat%0d act=%h exp=%h", i, {o_g[i], o_d[i], o_l[i]}, {e_g[i], e_d[i], e_l[i]});
      else n_pass++;
    end
    n_total++;
    if (o_start.size() < 2 || o_lastcyc.size() < 1) $display("FAIL prio_gap act=missing exp=2 packets");
    else if (o_start[1] - o_lastcyc[0] !== 10)
      $display("FAIL prio_gap act=%0d exp=10", o_start[1] - o_lastcyc[0]);
    else n_pass++;
    n_total++;
    if ({busy, mg} !== 3'b010) $display("FAIL prio_hold_grant act=%b exp=010", {busy, mg}); else n_pass++;
  endtask

  task automatic test_rr_alternate(input bit alt);
    reset_all(); sel_alt = alt;
    for (int k = 0; k < 3; k++) begin
      add_pkt(1, 1, 40'(8'h10 + k));
      add_pkt(2, 1, 40'(8'h20 + k));
    end
    build_expected(!alt);
    repeat (80) step();
    n_total++;
    if (o_g.size() !== 6) $display("FAIL rr_count alt=%0d act=%0d exp=6", alt, o_g.size()); else n_pass++;
    for (int i = 0; i < o_g.size() && i < e_g.size(); i++) begin
      n_total++;
      if ({o_g[i], o_d[i]} !== {e_g[i], e_d[i]})
        $display("FAIL rr_beat%0d alt=%0d act=%h exp=%h", i, alt, {o_g[i], o_d[i]}, {e_g[i], e_d[i]});
      else n_pass++;
    end
    if (alt) begin
      for (int i = 1; i < o_start.size() && i <= o_lastcyc.size(); i++) begin
        n_total++;
        if (o_start[i] - o_lastcyc[i-1] !== 2)
          $display("FAIL nogap%0d act=%0d exp=2", i, o_start[i] - o_lastcyc[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bus_reset_flush();
    int n;
    reset_all(); sel_alt = 1'b0;
    add_pkt(2, 5, 40'h0504030201);
    n = 0;
    while (o_d.size() < 2 && n < 20) begin step(); n++; end
    usb_reset = 1'b1;
    repeat (20) step();
    n_total++;
    if (o_d.size() !== 2) $display("FAIL flush_beats act=%0d exp=2", o_d.size()); else n_pass++;
    n_total++;
    if (flush_cnt !== 1) $display("FAIL flush_pulse act=%0d exp=1", flush_cnt); else n_pass++;
    n_total++;
    if (flush_mv_err !== 0) $display("FAIL flush_mvalid act=%0d exp=0", flush_mv_err); else n_pass++;
    n_total++;
    if (popped[2] !== 5) $display("FAIL flush_drain act=%0d exp=5", popped[2]); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL flush_end_busy act=%b exp=0", busy); else n_pass++;
    usb_reset = 1'b0;
  endtask

  task automatic test_idle_holdoff();
    int t_rise;
    reset_all(); sel_alt = 1'b1;
    usb_idle = 1'b0;
    add_pkt(1, 1, 40'h00000000A5);
    add_pkt(1, 1, 40'h000000005A);
    repeat (5) step();
    n_total++;
    if ({busy, o_start.size() == 0} !== 2'b01) $display("FAIL holdoff act=%b exp=01", {busy, o_start.size() == 0});
    else n_pass++;
    usb_idle = 1'b1;
    t_rise = cyc;
    repeat (10) step();
    n_total++;
    if (o_start.size() < 2 || o_lastcyc.size() < 1) $display("FAIL idle_rise act=missing exp=2 packets");
    else if ({o_start[0] - t_rise, o_start[1] - o_lastcyc[0]} !== {32'd0, 32'd2})
      $display("FAIL idle_rise act=%0d,%0d exp=0,2", o_start[0] - t_rise, o_start[1] - o_lastcyc[0]);
    else n_pass++;
  endtask

  task automatic test_ready_toggle();
    reset_all(); sel_alt = 1'b0;
    rdy_mode = 1;
    add_pkt(1, 4, 40'h00DDCCBBAA);
    build_expected(1'b1);
    repeat (20) step();
    n_total++;
    if (o_d.size() !== 4) $display("FAIL toggle_count act=%0d exp=4", o_d.size()); else n_pass++;
    for (int i = 0; i < o_d.size() && i < e_d.size(); i++) begin
      n_total++;
      if ({o_g[i], o_d[i], o_l[i]} !== {e_g[i], e_d[i], e_l[i]})
        $display("FAIL toggle_beat%0d act=%h exp=%h", i, {o_g[i], o_d[i], o_l[i]}, {e_g[i], e_d[i], e_l[i]});
      else n_pass++;
    end
    n_total++;
    if (tready_err !== 0) $display("FAIL toggle_tready act=%0d exp=0", tready_err); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] r;
    int n, bad;
    for (int it = 0; it < 3; it++) begin
      reset_all(); sel_alt = 1'b0;
      rdy_mode = 2;
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
          r = {$urandom(), $urandom()};
          add_pkt(s, int'($urandom_range(1, 5)), r[39:0]);
        end
      end
      build_expected(1'b1);
      n = 0;
      while ((q_data[0].size() + q_data[1].size() + q_data[2].size()) != 0 && n < 800) begin
        step(); n++;
      end
      repeat (12) step();
      n_total++;
      if (o_d.size() !== e_d.size()) $display("FAIL rand%0d_count act=%0d exp=%0d", it, o_d.size(), e_d.size());
      else n_pass++;
      bad = 0;
      for (int i = 0; i < o_d.size() && i < e_d.size(); i++)
        if ({o_g[i], o_d[i], o_l[i]} !== {e_g[i], e_d[i], e_l[i]}) bad++;
      for (int i = 1; i < o_start.size() && i <= o_lastcyc.size(); i++)
        if (o_start[i] - o_lastcyc[i-1] != 10) bad++;
      n_total++;
      if (bad + tready_err !== 0) $display("FAIL rand%0d_stream act=%0d errors exp=0", it, bad + tready_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_s1_packet();
    test_s0_priority_gap();
    test_rr_alternate(1'b0);
    test_rr_alternate(1'b1);
    test_bus_reset_flush();
    test_idle_holdoff();
    test_ready_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
